cache_ctrl_fsm: RTL

Request-sequencing controller sitting directly upstream of the four-way set array. It accepts single-byte CPU read/write requests and drives the set's lookup and write strobes. On a miss it performs dirty-victim write-back and line fill over a req/ack memory port, then returns data or an error to the CPU. It also keeps saturating hit/miss statistics.

---
 rtl/cache_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cache_ctrl_fsm
//
// Request sequencer for a four-way set array. Accepts single-byte CPU reads
// and writes, performs the set lookup, and on a miss writes back a dirty
// victim and fills the line over a req/ack memory port (write-allocate).
// Completion is signalled with a one-cycle cpu_done pulse, optionally
// flagged with cpu_err when the memory port times out. Saturating hit and
// miss counters are kept for statistics.
//
// Ports
//   clk, rst_b        clock; synchronous active-high reset
//   cpu_*             CPU request (req/we/addr/wdata) and response
//                     (ready/done/err/rdata)
//   set_addr          latched request address to the set array
//   set_try_read/_write  lookup strobes (LOOKUP cycle only)
//   set_cache_write   write strobe into the hit or freshly filled line
//   set_wdata         data written into the set
//   set_data/hit/dirty/valid, victim_addr   set array lookup results
//   mem_req/we/addr/wdata, mem_ack/rdata    memory port (req held until ack)
//   hit_count, miss_count                   saturating statistics
// ---------------------------------------------------------------------------
module cache_ctrl_fsm #(
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int MEM_TIMEOUT       = 16,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                         clk,
    input  logic                         rst_b,

    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
    input  logic [7:0]                   cpu_wdata,
    output logic                         cpu_ready,
    output logic                         cpu_done,
    output logic                         cpu_err,
    output logic [7:0]                   cpu_rdata,

    output logic [ADDRESS_WORD_SIZE-1:0] set_addr,
    output logic                         set_try_read,
    output logic                         set_try_write,
    output logic                         set_cache_write,
    output logic [7:0]                   set_wdata,
    input  logic [7:0]                   set_data,
    input  logic                         set_hit,
    input  logic                         set_dirty,
    input  logic                         set_valid,
    input  logic [ADDRESS_WORD_SIZE-1:0] victim_addr,

    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
    output logic [7:0]                   mem_wdata,
    input  logic                         mem_ack,
    input  logic [7:0]                   mem_rdata,

    output logic [STAT_WIDTH-1:0]        hit_count,
    output logic [STAT_WIDTH-1:0]        miss_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_UPDATE    = 3'd4;
    localparam logic [2:0] S_RESPOND   = 3'd5;

    // The counter only has to reach MEM_TIMEOUT-1: the cycle in which it
    // holds that value is the last one mem_req is allowed to stay high.
    localparam int               TMO_W    = $clog2(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [2:0]                   state;
    logic [2:0]                   state_n;
    logic [ADDRESS_WORD_SIZE-1:0] addr_q;
    logic                         we_q;
    logic [7:0]                   wdata_q;
    logic [7:0]                   rdata_q;
    logic [ADDRESS_WORD_SIZE-1:0] victim_addr_q;
    logic [7:0]                   victim_data_q;
    logic                         err_q;
    logic                         fill_gap;
    logic [TMO_W-1:0]             tmo_cnt;

    logic lookup;
    logic write_hit;
    logic mem_done;
    logic mem_timeout;

    // ------------------------------------------------------------------
    // Output decode (Moore on state, except the write-hit strobe which
    // follows set_hit combinationally in the LOOKUP cycle).
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the conditional
        // assignments, so no path can leave a value held and infer a latch.
        lookup          = (state == S_LOOKUP);
        write_hit       = lookup && we_q && set_hit;

        cpu_ready       = (state == S_IDLE);
        cpu_done        = (state == S_RESPOND);
        cpu_err         = (state == S_RESPOND) && err_q;
        cpu_rdata       = '0;
        if ((state == S_RESPOND) && !we_q) begin
            cpu_rdata = rdata_q;
        end

        set_addr        = addr_q;
        set_try_read    = lookup && !we_q;
        set_try_write   = lookup && we_q;
        set_cache_write = write_hit || (state == S_UPDATE);
        set_wdata       = '0;
        if (write_hit) begin
            set_wdata = wdata_q;
        end else if (state == S_UPDATE) begin
            // Write-allocate: a write miss stores the CPU byte into the
            // freshly filled line instead of the fetched byte.
            set_wdata = we_q ? wdata_q : rdata_q;
        end

        // The first FILL cycle after a write-back is left idle so the
        // memory sees req drop between the two transfers.
        mem_req         = (state == S_WRITEBACK) || ((state == S_FILL) && !fill_gap);
        mem_we          = (state == S_WRITEBACK);
        mem_addr        = '0;
        mem_wdata       = '0;
        if (state == S_WRITEBACK) begin
            mem_addr  = victim_addr_q;
            mem_wdata = victim_data_q;
        end else if (state == S_FILL) begin
            mem_addr  = addr_q;
        end

        // An ack on the final allowed cycle wins over the timeout.
        mem_done        = mem_req && mem_ack;
        mem_timeout     = mem_req && !mem_ack && (tmo_cnt == TMO_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    state_n = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (set_hit) begin
                    state_n = S_RESPOND;
                end else if (set_valid && set_dirty) begin
                    state_n = S_WRITEBACK;
                end else begin
                    state_n = S_FILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_done) begin
                    state_n = S_FILL;
                end else if (mem_timeout) begin
                    state_n = S_RESPOND;
                end
            end
            S_FILL: begin
                if (mem_done) begin
                    state_n = S_UPDATE;
                end else if (mem_timeout) begin
                    state_n = S_RESPOND;
                end
            end
            S_UPDATE:  state_n = S_RESPOND;
            S_RESPOND: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latches, timeout counter and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_b) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            err_q         <= 1'b0;
            fill_gap      <= 1'b0;
            tmo_cnt       <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state    <= state_n;
            fill_gap <= (state == S_WRITEBACK) && (state_n == S_FILL);

            // Counts cycles with mem_req high; any state change restarts it.
            if (mem_req && (state_n == state)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (set_hit) begin
                        if (!we_q) begin
                            rdata_q <= set_data;
                        end
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 1'b1;
                        end
                    end else begin
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        if (set_valid && set_dirty) begin
                            victim_addr_q <= victim_addr;
                            victim_data_q <= set_data;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_timeout) begin
                        err_q <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (mem_done) begin
                        rdata_q <= mem_rdata;
                    end else if (mem_timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
